// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX/RX state encodings and the parity helper.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop,
        RxWaitHigh
    } rx_state_e;

    // Parity bit that completes a word whose XOR-reduction is xor_all.
    function automatic logic parity_bit(input logic xor_all, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~xor_all : xor_all;
    endfunction

endpackage

// File: rtl/uart_param_if.sv
// Byte-level host handshake of the UART; the host side is master, the UART is slave.
interface uart_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_send;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output tx_data, tx_send,
        input  tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_send,
        output tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with synchronous clear, terminal and mid-bit strobes.
module uart_bit_timer #(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o,
    output logic mid_o
);
    localparam int unsigned CntW = $clog2(CLK_DIV);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == CntW'(CLK_DIV - 1));
        mid_o  = (cnt_q == CntW'(CLK_DIV / 2 - 1));
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART with start-bit glitch rejection and parity/framing errors.
module uart_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 868,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = PARITY_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic           clk100,
    input  logic           reset,
    input  logic           rx,
    output logic           tx,
    uart_param_if.slave    host
);
    // ---------------- TX ----------------
    tx_state_e            tx_st_q;
    logic                 tx_q, tx_busy_q, tx_par_q, tx_stop_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic [3:0]           tx_idx_q;
    logic                 tx_clr, tx_tick, tx_mid_unused;

    assign tx_clr = (tx_st_q == TxIdle) && host.tx_send;

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_tx_timer (
        .clk    (clk100),
        .rst    (reset),
        .clr_i  (tx_clr),
        .tick_o (tx_tick),
        .mid_o  (tx_mid_unused)
    );

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            tx_st_q    <= TxIdle;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_par_q   <= 1'b0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
        end else begin
            unique case (tx_st_q)
                TxIdle: if (host.tx_send) begin
                    tx_shift_q <= host.tx_data;
                    tx_par_q   <= parity_bit(^host.tx_data, PARITY);
                    tx_q       <= 1'b0;
                    tx_busy_q  <= 1'b1;
                    tx_st_q    <= TxStart;
                end
                TxStart: if (tx_tick) begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_idx_q   <= '0;
                    tx_st_q    <= TxData;
                end
                TxData: if (tx_tick) begin
                    if (tx_idx_q == 4'(DATA_BITS - 1)) begin
                        tx_stop_q <= 1'b0;
                        if (PARITY != PARITY_NONE) begin
                            tx_q    <= tx_par_q;
                            tx_st_q <= TxParity;
                        end else begin
                            tx_q    <= 1'b1;
                            tx_st_q <= TxStop;
                        end
                    end else begin
                        tx_idx_q   <= tx_idx_q + 4'd1;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                    end
                end
                TxParity: if (tx_tick) begin
                    tx_q    <= 1'b1;
                    tx_st_q <= TxStop;
                end
                TxStop: if (tx_tick) begin
                    if (tx_stop_q == 1'(STOP_BITS - 1)) begin
                        tx_busy_q <= 1'b0;
                        tx_st_q   <= TxIdle;
                    end else begin
                        tx_stop_q <= 1'b1;
                    end
                end
                default: tx_st_q <= TxIdle;
            endcase
        end
    end

    assign tx           = tx_q;
    assign host.tx_busy = tx_busy_q;

    // ---------------- RX ----------------
    rx_state_e            rx_st_q;
    logic                 rx_meta_q, rxs_q, rx_par_q;
    logic                 rx_valid_q, rx_perr_q, rx_ferr_q;
    logic [DATA_BITS-1:0] rx_shift_q, rx_data_q;
    logic [3:0]           rx_idx_q;
    logic                 rx_clr, rx_tick, rx_mid;

    // Clearing again at the confirmed start mid-point puts every later tick mid-bit.
    assign rx_clr = ((rx_st_q == RxIdle) && !rxs_q) ||
                    ((rx_st_q == RxStart) && rx_mid && !rxs_q);

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_rx_timer (
        .clk    (clk100),
        .rst    (reset),
        .clr_i  (rx_clr),
        .tick_o (rx_tick),
        .mid_o  (rx_mid)
    );

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rx_st_q    <= RxIdle;
            rx_par_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_idx_q   <= '0;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rx_valid_q <= 1'b0;
            unique case (rx_st_q)
                RxIdle: if (!rxs_q) rx_st_q <= RxStart;
                RxStart: if (rx_mid) begin
                    rx_idx_q <= '0;
                    rx_st_q  <= rxs_q ? RxIdle : RxData;
                end
                RxData: if (rx_tick) begin
                    rx_shift_q <= {rxs_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == 4'(DATA_BITS - 1)) begin
                        rx_st_q <= (PARITY != PARITY_NONE) ? RxParity : RxStop;
                    end else begin
                        rx_idx_q <= rx_idx_q + 4'd1;
                    end
                end
                RxParity: if (rx_tick) begin
                    rx_par_q <= rxs_q;
                    rx_st_q  <= RxStop;
                end
                RxStop: if (rx_tick) begin
                    rx_data_q  <= rx_shift_q;
                    rx_perr_q  <= (PARITY != PARITY_NONE) &&
                                  (rx_par_q != parity_bit(^rx_shift_q, PARITY));
                    rx_ferr_q  <= !rxs_q;
                    rx_valid_q <= 1'b1;
                    rx_st_q    <= rxs_q ? RxIdle : RxWaitHigh;
                end
                RxWaitHigh: if (rxs_q) rx_st_q <= RxIdle;
                default: rx_st_q <= RxIdle;
            endcase
        end
    end

    assign host.rx_data       = rx_data_q;
    assign host.rx_valid      = rx_valid_q;
    assign host.rx_parity_err = rx_perr_q;
    assign host.rx_frame_err  = rx_ferr_q;
endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: an 8N1 and an 8E1 instance at CLK_DIV=16.
module tb_uart_param;
    localparam int unsigned Div = 16;

    logic clk100 = 1'b0;
    logic reset  = 1'b1;
    logic loop_n = 1'b1, loop_e = 1'b1;
    logic rx_drv_n = 1'b1, rx_drv_e = 1'b1;
    logic tx_n, tx_e, rx_n, rx_e;

    always #5 clk100 = ~clk100;

    uart_param_if #(.DATA_BITS(8)) bus_n ();
    uart_param_if #(.DATA_BITS(8)) bus_e ();

    assign rx_n = loop_n ? tx_n : rx_drv_n;
    assign rx_e = loop_e ? tx_e : rx_drv_e;

    uart_param #(.CLK_DIV(Div), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clk100 (clk100),
        .reset  (reset),
        .rx     (rx_n),
        .tx     (tx_n),
        .host   (bus_n)
    );

    uart_param #(.CLK_DIV(Div), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
        .clk100 (clk100),
        .reset  (reset),
        .rx     (rx_e),
        .tx     (tx_e),
        .host   (bus_e)
    );

    int nchk = 0, nerr = 0;
    int vcnt_n = 0, vcnt_e = 0, bcnt_n = 0, bcnt_e = 0;

    always @(negedge clk100) begin
        if (bus_n.rx_valid === 1'b1) vcnt_n <= vcnt_n + 1;
        if (bus_e.rx_valid === 1'b1) vcnt_e <= vcnt_e + 1;
        if (bus_n.tx_busy === 1'b1) bcnt_n <= bcnt_n + 1;
        if (bus_e.tx_busy === 1'b1) bcnt_e <= bcnt_e + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;  // line[0] = start bit, line[9] = stop bit
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input bit sel_e, input logic [7:0] d);
        if (sel_e) begin
            bus_e.tx_data = d; bus_e.tx_send = 1'b1;
        end else begin
            bus_n.tx_data = d; bus_n.tx_send = 1'b1;
        end
        @(negedge clk100);
        bus_n.tx_send = 1'b0;
        bus_e.tx_send = 1'b0;
    endtask

    // Called on the negedge right after acceptance; samples the middle of each bit.
    task automatic sample_line(input bit sel_e, input logic [15:0] exp, input int n,
                               input string name);
        repeat (Div / 2) @(negedge clk100);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s bit%0d", name, i), sel_e ? tx_e : tx_n, exp[i]);
            repeat (Div) @(negedge clk100);
        end
    endtask

    task automatic wait_idle(input bit sel_e);
        int k = 0;
        while ((sel_e ? bus_e.tx_busy : bus_n.tx_busy) && k < 400) begin
            @(negedge clk100);
            k++;
        end
        chk("tx idle in time", k < 400, 1);
    endtask

    task automatic bang(input bit sel_e, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel_e) rx_drv_e = bits[i];
            else       rx_drv_n = bits[i];
            repeat (Div) @(negedge clk100);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v0, b0;
        vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
        vecs[1] = '{8'h00, 10'b1_0000_0000_0};
        vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
        vecs[3] = '{8'h3C, 10'b1_0011_1100_0};
        bus_n.tx_data = '0; bus_n.tx_send = 1'b0;
        bus_e.tx_data = '0; bus_e.tx_send = 1'b0;

        repeat (3) @(negedge clk100);
        chk("reset tx", tx_n, 1);
        chk("reset tx_busy", bus_n.tx_busy, 0);
        chk("reset rx_data", bus_n.rx_data, 0);
        chk("reset rx_valid", bus_n.rx_valid, 0);
        chk("reset parity_err", bus_n.rx_parity_err, 0);
        chk("reset frame_err", bus_n.rx_frame_err, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk100);

        // 8N1 loopback vectors
        foreach (vecs[i]) begin
            v0 = vcnt_n; b0 = bcnt_n;
            send(0, vecs[i].data);
            sample_line(0, 16'(vecs[i].line), 10, $sformatf("8N1 %0h", vecs[i].data));
            wait_idle(0);
            repeat (20) @(negedge clk100);
            chk("8N1 busy cycles", bcnt_n - b0, 160);
            chk("8N1 rx_valid pulses", vcnt_n - v0, 1);
            chk("8N1 rx_data", bus_n.rx_data, vecs[i].data);
            chk("8N1 parity_err", bus_n.rx_parity_err, 0);
            chk("8N1 frame_err", bus_n.rx_frame_err, 0);
        end

        // 8E1: 0x07 has three ones, so the even parity bit is 1
        v0 = vcnt_e; b0 = bcnt_e;
        send(1, 8'h07);
        sample_line(1, 16'(11'b1_1_0000_0111_0), 11, "8E1 07");
        wait_idle(1);
        repeat (20) @(negedge clk100);
        chk("8E1 busy cycles", bcnt_e - b0, 176);
        chk("8E1 rx_valid pulses", vcnt_e - v0, 1);
        chk("8E1 rx_data", bus_e.rx_data, 8'h07);
        chk("8E1 parity_err clean", bus_e.rx_parity_err, 0);

        loop_e = 1'b0;
        v0 = vcnt_e;
        bang(1, 16'(11'b1_0_0000_0111_0), 11);
        repeat (4) @(negedge clk100);
        chk("8E1 bad parity valid", vcnt_e - v0, 1);
        chk("8E1 bad parity data", bus_e.rx_data, 8'h07);
        chk("8E1 parity_err set", bus_e.rx_parity_err, 1);
        chk("8E1 frame_err clear", bus_e.rx_frame_err, 0);

        // Start-bit glitch is rejected, next frame still received
        loop_n = 1'b0;
        v0 = vcnt_n;
        rx_drv_n = 1'b0;
        repeat (4) @(negedge clk100);
        rx_drv_n = 1'b1;
        repeat (40) @(negedge clk100);
        chk("glitch no valid", vcnt_n - v0, 0);
        bang(0, 16'(10'b1_0101_1010_0), 10);
        repeat (4) @(negedge clk100);
        chk("after glitch valid", vcnt_n - v0, 1);
        chk("after glitch data", bus_n.rx_data, 8'h5A);

        // Framing error / break: low stop bit, line held low
        v0 = vcnt_n;
        bang(0, 16'(10'b0_0011_0011_0), 10);
        repeat (64) @(negedge clk100);
        chk("break valid", vcnt_n - v0, 1);
        chk("break data", bus_n.rx_data, 8'h33);
        chk("break frame_err", bus_n.rx_frame_err, 1);
        chk("break parity_err", bus_n.rx_parity_err, 0);
        rx_drv_n = 1'b1;
        repeat (40) @(negedge clk100);
        chk("break no new frame", vcnt_n - v0, 1);
        chk("frame_err held", bus_n.rx_frame_err, 1);
        bang(0, 16'(10'b1_1100_0011_0), 10);
        repeat (4) @(negedge clk100);
        chk("post break valid", vcnt_n - v0, 2);
        chk("post break data", bus_n.rx_data, 8'hC3);
        chk("post break frame_err", bus_n.rx_frame_err, 0);

        // tx_send while busy is ignored
        loop_n = 1'b1;
        repeat (5) @(negedge clk100);
        v0 = vcnt_n; b0 = bcnt_n;
        send(0, 8'h96);
        repeat (30) @(negedge clk100);
        send(0, 8'hFF);
        wait_idle(0);
        repeat (20) @(negedge clk100);
        chk("ignored send busy cycles", bcnt_n - b0, 160);
        chk("ignored send valid", vcnt_n - v0, 1);
        chk("ignored send data", bus_n.rx_data, 8'h96);
        chk("ignored send not queued", bus_n.tx_busy, 0);

        // Reset during data bit 3 of 0xA5 (a 0 bit)
        v0 = vcnt_n;
        send(0, 8'hA5);
        repeat (Div * 4 + Div / 2) @(negedge clk100);
        chk("pre-reset tx low", tx_n, 0);
        reset = 1'b1;
        #1;
        chk("mid-frame reset tx", tx_n, 1);
        chk("mid-frame reset busy", bus_n.tx_busy, 0);
        repeat (3) @(negedge clk100);
        reset = 1'b0;
        repeat (200) @(negedge clk100);
        chk("aborted frame no valid", vcnt_n - v0, 0);
        chk("aborted rx_data reset", bus_n.rx_data, 0);

        v0 = vcnt_n;
        send(0, 8'h3C);
        wait_idle(0);
        repeat (20) @(negedge clk100);
        chk("post reset valid", vcnt_n - v0, 1);
        chk("post reset data", bus_n.rx_data, 8'h3C);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
